// File: rtl/pc_fetch_stage_pkg.sv
// Shared fetch-side definitions: datapath defaults and fetch FSM encoding,
// also consumed by the next-PC mux and decode.
package pc_fetch_stage_pkg;

  localparam int unsigned       DEF_DATA_W   = 32;
  localparam logic [31:0]       DEF_RESET_PC = 32'h0000_0000;
  localparam int unsigned       DEF_PC_STEP  = 4;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StReq     = 2'd1,
    StWaitOut = 2'd2,
    StDrop    = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_out_buf.sv
// Single-entry valid/ready register holding {pc, instr} between fetch and decode.
module fetch_out_buf #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_load_pc,
  input  logic [DATA_W-1:0] i_load_instr,
  input  logic              i_consume,
  input  logic              i_flush,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_pc,
  output logic [DATA_W-1:0] o_instr
);

  logic              r_valid;
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_instr;

  // Flush beats load beats consume; a load in the consume cycle keeps valid high.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_pc    <= '0;
      r_instr <= '0;
    end else if (i_flush) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_load_pc;
      r_instr <= i_load_instr;
    end else if (i_consume && r_valid) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_instr = r_instr;

endmodule

// File: rtl/pc_fetch_stage.sv
// Program counter and instruction fetch: held imem requests, redirect handling
// and a one-entry output buffer toward decode.
module pc_fetch_stage
  import pc_fetch_stage_pkg::*;
#(
  parameter int unsigned       DATA_W   = DEF_DATA_W,
  parameter logic [DATA_W-1:0] RESET_PC = DATA_W'(DEF_RESET_PC),
  parameter int unsigned       PC_STEP  = DEF_PC_STEP
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_stall,
  input  logic              i_redirect_valid,
  input  logic [DATA_W-1:0] i_redirect_pc,
  output logic [DATA_W-1:0] o_pc_plus4,
  output logic              o_imem_req,
  output logic [DATA_W-1:0] o_imem_addr,
  input  logic              i_imem_ack,
  input  logic [DATA_W-1:0] i_imem_rdata,
  output logic              o_if_valid,
  output logic [DATA_W-1:0] o_if_pc,
  output logic [DATA_W-1:0] o_if_instr,
  input  logic              i_if_ready
);

  fetch_state_e      r_state;
  logic [DATA_W-1:0] r_pc;
  logic [DATA_W-1:0] r_req_addr;
  logic [DATA_W-1:0] r_pending;

  fetch_state_e      w_state_next;
  logic [DATA_W-1:0] w_pc_next;
  logic [DATA_W-1:0] w_req_addr_next;
  logic [DATA_W-1:0] w_pending_next;

  logic              w_buf_load;
  logic [DATA_W-1:0] w_buf_instr;
  logic              w_buf_flush;
  logic              w_buf_free;
  logic [DATA_W-1:0] w_redirect_aligned;
  logic [DATA_W-1:0] w_req_addr_step;

  assign w_buf_free         = !o_if_valid || i_if_ready;
  assign w_redirect_aligned = {i_redirect_pc[DATA_W-1:2], 2'b00};
  assign w_req_addr_step    = r_req_addr + DATA_W'(PC_STEP);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_pc       <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_pending  <= '0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_req_addr <= w_req_addr_next;
      r_pending  <= w_pending_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_req_addr_next = r_req_addr;
    w_pending_next  = r_pending;
    w_buf_load      = 1'b0;
    w_buf_instr     = i_imem_rdata;
    w_buf_flush     = i_redirect_valid;

    unique case (r_state)
      StIdle: begin
        // A redirect here only retargets pc; the next IDLE exit fetches from it.
        if (i_redirect_valid) begin
          w_pc_next = w_redirect_aligned;
        end else if (!i_stall) begin
          w_req_addr_next = r_pc;
          w_state_next    = StReq;
        end
      end
      StReq: begin
        if (i_redirect_valid) begin
          w_pc_next    = w_redirect_aligned;
          w_state_next = i_imem_ack ? StIdle : StDrop;
        end else if (i_imem_ack) begin
          if (w_buf_free) begin
            w_buf_load = 1'b1;
            w_pc_next  = w_req_addr_step;
            if (!i_stall) begin
              w_req_addr_next = w_req_addr_step;
            end else begin
              w_state_next = StIdle;
            end
          end else begin
            w_pending_next = i_imem_rdata;
            w_state_next   = StWaitOut;
          end
        end
      end
      StWaitOut: begin
        if (i_redirect_valid) begin
          w_pc_next    = w_redirect_aligned;
          w_state_next = StIdle;
        end else if (i_if_ready) begin
          w_buf_load   = 1'b1;
          w_buf_instr  = r_pending;
          w_pc_next    = w_req_addr_step;
          w_state_next = StIdle;
        end
      end
      StDrop: begin
        // Old request stays on the bus until acked; its data is thrown away.
        if (i_redirect_valid) begin
          w_pc_next = w_redirect_aligned;
        end
        if (i_imem_ack) begin
          w_state_next = StIdle;
        end
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  fetch_out_buf #(
    .DATA_W (DATA_W)
  ) u_out_buf (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_load       (w_buf_load),
    .i_load_pc    (r_req_addr),
    .i_load_instr (w_buf_instr),
    .i_consume    (i_if_ready),
    .i_flush      (w_buf_flush),
    .o_valid      (o_if_valid),
    .o_pc         (o_if_pc),
    .o_instr      (o_if_instr)
  );

  assign o_pc_plus4  = r_pc + DATA_W'(PC_STEP);
  assign o_imem_req  = (r_state == StReq) || (r_state == StDrop);
  assign o_imem_addr = r_req_addr;

endmodule

// File: doc/pc_fetch_stage.md
Name: pc_fetch_stage

Overview:
- Program-counter and instruction-fetch stage, directly upstream of the 32-bit two-input next-PC mux.
- Drives the mux's sequential input (pc_plus4) and consumes the mux output as redirect_pc.
- Issues held-until-acknowledged requests to instruction memory.
- Presents fetched instructions to decode through a single-entry valid/ready output buffer.

Parameters:
- DATA_W, 32, width of PC, addresses and instruction words
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- PC_STEP, 4, sequential PC increment in bytes

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous reset, active-high
- stall  in  1  blocks issue of new fetch requests; does not abort an outstanding one
- redirect_valid  in  1  one-cycle pulse, load redirect_pc (branch/jump taken)
- redirect_pc  in  DATA_W  new PC, from next-PC mux output O
- pc_plus4  out  DATA_W  pc + PC_STEP, combinational, feeds next-PC mux input A
- imem_req  out  1  fetch request, held until imem_ack
- imem_addr  out  DATA_W  fetch address, stable while imem_req=1
- imem_ack  in  1  memory accepted request, imem_rdata valid this cycle
- imem_rdata  in  DATA_W  instruction word
- if_valid  out  1  output buffer holds an instruction
- if_pc  out  DATA_W  PC of buffered instruction
- if_instr  out  DATA_W  buffered instruction
- if_ready  in  1  decode accepts buffer this cycle

Behaviour:
- Reset (sync, any state): pc=RESET_PC, req_addr=RESET_PC, state=IDLE, if_valid=0, if_pc=0, if_instr=0, pending=0, imem_req=0. An outstanding request is abandoned; imem shares rst.
- Arithmetic: all PC math is mod 2^DATA_W, so 32'hFFFF_FFFC+4 wraps to 0. redirect_pc[1:0] is forced to 0 on load.
- imem_req=1 only in REQ and DROP. imem_addr=req_addr at all times.
- "buf_free" = !if_valid || if_ready. The buffer is consumed on if_valid && if_ready; if_valid clears unless reloaded the same cycle.
- IDLE: if !stall, set req_addr<=pc and go to REQ.
- REQ: redirect_valid has priority over everything.
  - redirect && ack: discard rdata, pc<=redirect_pc, go to IDLE.
  - redirect && !ack: pc<=redirect_pc, go to DROP.
  - ack && buf_free: load buffer {1, req_addr, rdata}, pc<=req_addr+PC_STEP. If !stall, req_addr<=req_addr+PC_STEP and stay in REQ (back-to-back fetch); else go to IDLE.
  - ack && !buf_free: pending<=rdata, go to WAIT_OUT.
- WAIT_OUT: imem_req=0.
  - redirect: flush buffer (if_valid<=0), pending dropped, pc<=redirect_pc, go to IDLE.
  - if_ready: buffer<={1, req_addr, pending}, pc<=req_addr+PC_STEP, go to IDLE.
- DROP: keep requesting the old req_addr.
  - Further redirects update pc only (last one wins).
  - On ack: discard rdata, go to IDLE.
- Redirect in any state clears if_valid in the same edge, except a load that is discarded by that redirect.
- Stall: honoured only at IDLE exit and at back-to-back reissue. It never drops imem_req mid-request and never blocks the output buffer.
- Latency: first edge with rst=0 moves IDLE→REQ. With a same-cycle ack, if_valid rises on the edge after the ack. Peak throughput is 1 instruction/cycle.

Decomposition:
- Shared package/include: FSM state encodings (IDLE, REQ, WAIT_OUT, DROP, 2 bits), DATA_W, RESET_PC and PC_STEP defaults, shared with the next-PC mux and decode.
- One sub-module, fetch_out_buf: single-entry valid/ready register holding {pc, instr}, with load, consume and flush inputs.

Test Plan:
- Reset, then no stall, imem_ack high every REQ cycle, if_ready=1 → imem_addr = 0,4,8,12 on consecutive cycles; if_pc follows one cycle later; pc_plus4 = pc+4.
- Hold imem_ack low 3 cycles with addr 8 requested → imem_req and imem_addr=8 stable all 3 cycles; data captured only on the ack cycle.
- if_ready=0 when ack for addr 4 arrives while buffer holds addr 0 → WAIT_OUT, imem_req=0. After if_ready=1: if_pc=0 consumed, then if_pc=4 with the correct instr.
- redirect_valid with redirect_pc=32'h0000_0103 during an unacked request to 16 → DROP: addr 16 is held until ack and its data discarded. Next request goes to 32'h100, if_valid=0 meanwhile.
- redirect and imem_ack in the same cycle → rdata is not loaded; next imem_addr = redirect_pc.
- pc=32'hFFFF_FFFC → pc_plus4=0 and next fetch address 0. Assert rst mid-REQ → next cycle imem_req=0, if_valid=0, pc=RESET_PC.
